// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared constants for the 9x9 box-average filter datapath
package filter_pkg;
    localparam int WIN      = 9;       // window side
    localparam int PW       = 10;      // pixel width
    localparam int NPIX     = WIN * WIN;
    localparam int RSUM_W   = 14;      // 9 * 1023 = 9207
    localparam int WSUM_W   = 17;      // 81 * 1023 = 82863
    localparam int RECIP81  = 207127;  // ceil(2^24 / 81), exact floor(S/81) over 0..82863
    localparam int RECIP_SH = 24;
    localparam int PROD_W   = 35;
endpackage

// File: rtl/row_adder.sv
// rtl/row_adder.sv - combinational sum of one window row of WIN pixels
// Ports:
//   pix_i  in   WIN*PW   row pixels, pixel 0 at the LSBs
//   sum_o  out  RSUM_W   unsigned sum of the row
module row_adder
    import filter_pkg::*;
(
    input  logic [WIN*PW-1:0] pix_i,
    output logic [RSUM_W-1:0] sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < WIN; i++) begin
            sum_o = sum_o + RSUM_W'(pix_i[i*PW +: PW]);
        end
    end

endmodule

// File: rtl/operation.sv
// rtl/operation.sv - 3-stage pipelined 9x9 box-average (mean) filter core
// Ports:
//   clk       in   1            rising-edge clock
//   rst       in   1            asynchronous active-high reset, clears all stages
//   refresh   in   1            synchronous flush, clears all stages
//   data_bus  in   WIN*WIN*PW   window, pixel k = 9*row + col at bits [10k+9:10k]
//   out       out  PW           registered floor(sum / 81), 3 edges after capture
module operation #(
    parameter int WIN = filter_pkg::WIN,
    parameter int PW  = filter_pkg::PW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    input  logic [WIN*WIN*PW-1:0] data_bus,
    output logic [PW-1:0]         out
);
    import filter_pkg::RSUM_W;
    import filter_pkg::WSUM_W;
    import filter_pkg::RECIP81;
    import filter_pkg::RECIP_SH;
    import filter_pkg::PROD_W;

    logic [RSUM_W-1:0] row_sum_d [WIN];
    logic [RSUM_W-1:0] row_sum_q [WIN];
    logic [WSUM_W-1:0] wsum_d;
    logic [WSUM_W-1:0] wsum_q;
    logic [PROD_W-1:0] prod;
    logic [PW-1:0]     out_d;
    logic              prod_unused;

    // Stage 1 adders: one per window row
    for (genvar r = 0; r < WIN; r++) begin : g_row
        row_adder u_row_adder (
            .pix_i (data_bus[r*WIN*PW +: WIN*PW]),
            .sum_o (row_sum_d[r])
        );
    end

    // Stage 2 adder: window sum of the registered row sums
    always_comb begin
        wsum_d = '0;
        for (int r = 0; r < WIN; r++) begin
            wsum_d = wsum_d + WSUM_W'(row_sum_q[r]);
        end
    end

    // Stage 3: divide by 81 via reciprocal multiply; result never exceeds 1023
    assign prod        = PROD_W'(wsum_q) * PROD_W'(RECIP81);
    assign out_d       = prod[RECIP_SH +: PW];
    assign prod_unused = ^{prod[PROD_W-1:RECIP_SH+PW], prod[RECIP_SH-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < WIN; r++) row_sum_q[r] <= '0;
            wsum_q <= '0;
            out    <= '0;
        end else if (refresh) begin
            for (int r = 0; r < WIN; r++) row_sum_q[r] <= '0;
            wsum_q <= '0;
            out    <= '0;
        end else begin
            for (int r = 0; r < WIN; r++) row_sum_q[r] <= row_sum_d[r];
            wsum_q <= wsum_d;
            out    <= out_d;
        end
    end

endmodule

// File: tb/tb_operation.sv
// tb/tb_operation.sv - self-checking bench for the box-average filter core
module tb_operation;

    logic         clk = 1'b0;
    logic         rst;
    logic         refresh;
    logic [809:0] data_bus;
    logic [9:0]   out_w;

    int checks   = 0;
    int failures = 0;
    int q[$];

    operation dut (
        .clk      (clk),
        .rst      (rst),
        .refresh  (refresh),
        .data_bus (data_bus),
        .out      (out_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] base;
        logic [9:0] special;
        int         nspecial;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: mean of the 81 pixels with plain integer division
    function automatic int win_mean(input logic [809:0] w);
        int s = 0;
        for (int k = 0; k < 81; k++) s += int'(w[k*10 +: 10]);
        return s / 81;
    endfunction

    function automatic logic [809:0] make_win(input logic [9:0] base,
                                              input logic [9:0] special, input int ns);
        logic [809:0] w;
        for (int k = 0; k < 81; k++) w[k*10 +: 10] = (k < ns) ? special : base;
        return w;
    endfunction

    function automatic logic [809:0] rand_win();
        logic [809:0] w;
        for (int k = 0; k < 81; k++) w[k*10 +: 10] = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    // Model: out after edge k is the mean of the window captured at edge k-2
    function automatic void model_clear();
        q = {0, 0, 0};
    endfunction

    function automatic void model_push(input int v);
        q.push_back(v);
        void'(q.pop_front());
    endfunction

    task automatic cyc(input logic [809:0] w, input logic rf, input string name, input bit check);
        data_bus = w;
        refresh  = rf;
        @(posedge clk);
        #1;
        if (rst || rf) model_clear();
        else           model_push(win_mean(w));
        if (check) chk(name, int'(out_w), q[0]);
    endtask

    initial begin
        logic [809:0] w;
        tbl[0] = '{"all1023",  10'd1023, 10'd1023, 0, 10'd1023};
        tbl[1] = '{"all1",     10'd1,    10'd1,    0, 10'd1};
        tbl[2] = '{"all500",   10'd500,  10'd500,  0, 10'd500};
        tbl[3] = '{"pix0only", 10'd0,    10'd1023, 1, 10'd12};
        tbl[4] = '{"80ones",   10'd1,    10'd0,    1, 10'd0};
        tbl[5] = '{"81ones",   10'd1,    10'd1,    0, 10'd1};
        tbl[6] = '{"k1022",    10'd1023, 10'd1022, 1, 10'd1022};
        tbl[7] = '{"zeros",    10'd0,    10'd0,    0, 10'd0};

        // Reset held two cycles with random data
        rst = 1'b1; refresh = 1'b0; data_bus = rand_win();
        model_clear();
        #1;
        chk("reset_async", int'(out_w), 0);
        for (int i = 0; i < 2; i++) cyc(rand_win(), 1'b0, "reset_hold", 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc('0, 1'b0, "post_reset_zero", 1'b1);

        // Constant / boundary windows: held 3 edges, compared to table constant
        for (int t = 0; t < 8; t++) begin
            w = make_win(tbl[t].base, tbl[t].special, tbl[t].nspecial);
            cyc(w, 1'b0, tbl[t].name, 1'b0);
            cyc(w, 1'b0, tbl[t].name, 1'b0);
            cyc(w, 1'b0, tbl[t].name, 1'b1);
            chk({tbl[t].name, "_const"}, int'(out_w), int'(tbl[t].exp));
        end

        // Ramp, reverse ramp, then random windows back-to-back
        for (int k = 0; k < 81; k++) w[k*10 +: 10] = 10'(k);
        cyc(w, 1'b0, "ramp", 1'b1);
        for (int k = 0; k < 81; k++) w[k*10 +: 10] = 10'(80 - k);
        cyc(w, 1'b0, "ramp_rev", 1'b1);
        for (int i = 0; i < 60; i++) cyc(rand_win(), 1'b0, "random_stream", 1'b1);
        // Random stream with occasional refresh pulses
        for (int i = 0; i < 60; i++)
            cyc(rand_win(), ($urandom_range(0, 7) == 0), "random_refresh", 1'b1);

        // Refresh pulse mid-stream at full scale
        w = make_win(10'd1023, 10'd1023, 0);
        for (int i = 0; i < 3; i++) cyc(w, 1'b0, "pre_refresh", 1'b1);
        chk("pre_refresh_full", int'(out_w), 1023);
        cyc(w, 1'b1, "refresh_edge", 1'b1);
        chk("refresh_zero0", int'(out_w), 0);
        cyc(w, 1'b0, "refresh_after1", 1'b1);
        chk("refresh_zero1", int'(out_w), 0);
        cyc(w, 1'b0, "refresh_after2", 1'b1);
        chk("refresh_zero2", int'(out_w), 0);
        cyc(w, 1'b0, "refresh_after3", 1'b1);
        chk("refresh_back", int'(out_w), 1023);

        // Refresh held several cycles
        for (int i = 0; i < 4; i++) cyc(w, 1'b1, "refresh_hold", 1'b1);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) cyc(w, 1'b0, "pre_rst", 1'b1);
        chk("pre_rst_full", int'(out_w), 1023);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_drop", int'(out_w), 0);
        @(posedge clk);
        #1;
        chk("async_rst_edge", int'(out_w), 0);
        rst = 1'b0;
        model_clear();
        cyc(w, 1'b0, "refill1", 1'b1);
        chk("refill1_zero", int'(out_w), 0);
        cyc(w, 1'b0, "refill2", 1'b1);
        chk("refill2_zero", int'(out_w), 0);
        cyc(w, 1'b0, "refill3", 1'b1);
        chk("refill3_full", int'(out_w), 1023);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
